// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle controller: state enum,
// instruction field codes, ALU operation codes and writeback-source codes.
package multicycle_pkg;

  typedef enum logic [4:0] {
    S_FETCH,
    S_FETCH_WAIT,
    S_FETCH_LD,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_ACC,
    S_MEM_WAIT,
    S_WB_MEM,
    S_BRANCH,
    S_LUI_WB,
    S_JUMP,
    S_JAL,
    S_EXC,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_HALT = 6'h0D;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [3:0] M2R_ALU       = 4'd0;
  localparam logic [3:0] M2R_LT        = 4'd1;
  localparam logic [3:0] M2R_MDR       = 4'd3;
  localparam logic [3:0] M2R_PC        = 4'd4;
  localparam logic [3:0] M2R_EXC_CONST = 4'd5;
  localparam logic [3:0] M2R_LUI       = 4'd7;

  // One bundle of every controller output, so the whole set can be zeroed at once.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] mem_to_reg;
    logic       epc_write;
    logic       halted;
  } ctrl_t;

  function automatic logic is_rtype_alu(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic logic [2:0] alu_from_funct(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the controller and the datapath: IR decode fields and ALU
// flags in, every mux select and write enable out.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;

  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic       i_or_d;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] mem_to_reg;
  logic       epc_write;
  logic       halted;

  modport master (
    input  opcode, funct, zero, overflow,
    output pc_write, pc_write_cond, branch_ne, i_or_d, mem_write, ir_write,
           reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
           mem_to_reg, epc_write, halted
  );

  modport slave (
    output opcode, funct, zero, overflow,
    input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_write, ir_write,
           reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
           mem_to_reg, epc_write, halted
  );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_counter.sv
// Load/decrement counter used to count out the fixed memory latency.
// done is raised on the last wait cycle; the count saturates at zero.
module mem_wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign done = (cnt_reg <= W'(1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle 32-bit datapath.
// Optional build macro CTRL_OVF_TRAP_EN: signed overflow on add/sub/addi traps to EXC.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int         MEM_WAIT    = 2,
  parameter logic [1:0] EXC_VEC_SEL = 2'd3
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   bus
);

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);
  localparam bit         NO_WAIT   = (MEM_WAIT == 0);

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl_next;
  ctrl_t  ctrl_out;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_done;
  logic   is_sw;
  state_t mem_done_state;

  mem_wait_counter #(.W(3)) u_wait (
    .clk      (clk),
    .srst     (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WAIT_LOAD),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  assign is_sw          = (bus.opcode == OP_SW);
  assign mem_done_state = is_sw ? S_FETCH : S_WB_MEM;

  always_comb begin
    state_next = state_reg;
    ctrl_next  = '0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    case (state_reg)
      S_FETCH: begin
        cnt_load   = 1'b1;
        state_next = NO_WAIT ? S_FETCH_LD : S_FETCH_WAIT;
      end

      S_FETCH_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) state_next = S_FETCH_LD;
      end

      S_FETCH_LD: begin
        ctrl_next.ir_write  = 1'b1;
        ctrl_next.alu_src_b = 2'd1;
        ctrl_next.alu_op    = ALU_ADD;
        ctrl_next.pc_write  = 1'b1;
        state_next          = S_DECODE;
      end

      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        ctrl_next.alu_src_b = 2'd3;
        ctrl_next.alu_op    = ALU_ADD;
        case (bus.opcode)
          OP_RTYPE: begin
            if (bus.funct == FN_HALT)          state_next = S_HALT;
            else if (is_rtype_alu(bus.funct))  state_next = S_EXEC_R;
            else                               state_next = S_EXC;
          end
          OP_ADDI:         state_next = S_EXEC_I;
          OP_LW, OP_SW:    state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:  state_next = S_BRANCH;
          OP_LUI:          state_next = S_LUI_WB;
          OP_J:            state_next = S_JUMP;
          OP_JAL:          state_next = S_JAL;
          default:         state_next = S_EXC;
        endcase
      end

      S_EXEC_R: begin
        ctrl_next.alu_src_a = 1'b1;
        ctrl_next.alu_op    = alu_from_funct(bus.funct);
        state_next          = S_WB_R;
`ifdef CTRL_OVF_TRAP_EN
        if (bus.overflow && ((bus.funct == FN_ADD) || (bus.funct == FN_SUB)))
          state_next = S_EXC;
`endif
      end

      S_WB_R: begin
        ctrl_next.reg_write  = 1'b1;
        ctrl_next.reg_dst    = 2'd1;
        ctrl_next.mem_to_reg = (bus.funct == FN_SLT) ? M2R_LT : M2R_ALU;
        state_next           = S_FETCH;
      end

      S_EXEC_I: begin
        ctrl_next.alu_src_a = 1'b1;
        ctrl_next.alu_src_b = 2'd2;
        ctrl_next.alu_op    = ALU_ADD;
        state_next          = S_WB_I;
`ifdef CTRL_OVF_TRAP_EN
        if (bus.overflow) state_next = S_EXC;
`endif
      end

      S_WB_I: begin
        ctrl_next.reg_write  = 1'b1;
        ctrl_next.mem_to_reg = M2R_ALU;
        state_next           = S_FETCH;
      end

      S_MEM_ADDR: begin
        ctrl_next.alu_src_a = 1'b1;
        ctrl_next.alu_src_b = 2'd2;
        ctrl_next.alu_op    = ALU_ADD;
        state_next          = S_MEM_ACC;
      end

      S_MEM_ACC: begin
        ctrl_next.i_or_d    = 1'b1;
        ctrl_next.mem_write = is_sw;
        cnt_load            = 1'b1;
        state_next          = NO_WAIT ? mem_done_state : S_MEM_WAIT;
      end

      S_MEM_WAIT: begin
        // Address and write strobe stay up until the memory has absorbed them.
        ctrl_next.i_or_d    = 1'b1;
        ctrl_next.mem_write = is_sw;
        cnt_dec             = 1'b1;
        if (cnt_done) state_next = mem_done_state;
      end

      S_WB_MEM: begin
        ctrl_next.reg_write  = 1'b1;
        ctrl_next.mem_to_reg = M2R_MDR;
        state_next           = S_FETCH;
      end

      S_BRANCH: begin
        ctrl_next.alu_src_a     = 1'b1;
        ctrl_next.alu_op        = ALU_SUB;
        ctrl_next.pc_write_cond = 1'b1;
        ctrl_next.pc_source     = 2'd1;
        ctrl_next.branch_ne     = (bus.opcode == OP_BNE);
        state_next              = S_FETCH;
      end

      S_LUI_WB: begin
        ctrl_next.reg_write  = 1'b1;
        ctrl_next.mem_to_reg = M2R_LUI;
        state_next           = S_FETCH;
      end

      S_JUMP: begin
        ctrl_next.pc_write  = 1'b1;
        ctrl_next.pc_source = 2'd2;
        state_next          = S_FETCH;
      end

      S_JAL: begin
        ctrl_next.reg_write  = 1'b1;
        ctrl_next.reg_dst    = 2'd2;
        ctrl_next.mem_to_reg = M2R_PC;
        ctrl_next.pc_write   = 1'b1;
        ctrl_next.pc_source  = 2'd2;
        state_next           = S_FETCH;
      end

      S_EXC: begin
        ctrl_next.epc_write  = 1'b1;
        ctrl_next.pc_write   = 1'b1;
        ctrl_next.pc_source  = EXC_VEC_SEL;
        ctrl_next.reg_write  = 1'b1;
        ctrl_next.reg_dst    = 2'd2;
        ctrl_next.mem_to_reg = M2R_EXC_CONST;
        state_next           = S_FETCH;
      end

      S_HALT: begin
        ctrl_next.halted = 1'b1;
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted so an aborted instruction writes nothing.
  assign ctrl_out = reset ? '0 : ctrl_next;

  assign bus.pc_write      = ctrl_out.pc_write;
  assign bus.pc_write_cond = ctrl_out.pc_write_cond;
  assign bus.branch_ne     = ctrl_out.branch_ne;
  assign bus.i_or_d        = ctrl_out.i_or_d;
  assign bus.mem_write     = ctrl_out.mem_write;
  assign bus.ir_write      = ctrl_out.ir_write;
  assign bus.reg_write     = ctrl_out.reg_write;
  assign bus.reg_dst       = ctrl_out.reg_dst;
  assign bus.alu_src_a     = ctrl_out.alu_src_a;
  assign bus.alu_src_b     = ctrl_out.alu_src_b;
  assign bus.alu_op        = ctrl_out.alu_op;
  assign bus.pc_source     = ctrl_out.pc_source;
  assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
  assign bus.epc_write     = ctrl_out.epc_write;
  assign bus.halted        = ctrl_out.halted;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences the multicycle 32-bit datapath: fetch, decode, execute, memory access and writeback.
- Drives every datapath select and enable, including the 4-bit writeback-source select of the register-file write mux.
- Sits between the instruction register decode fields and the datapath muxes and enables.
- Memory has a fixed latency, which this block counts out.

Parameters:
- MEM_WAIT, 2: extra wait cycles after issuing a memory read or write before the data is valid. Legal range 0..7.
- EXC_VEC_SEL, 3: pc_source code selecting the exception vector.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed overflow
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  branch PC load; datapath qualifies it with zero for beq and with !zero for bne
- branch_ne  out  1  selects the !zero qualification
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_write  out  1  register-file write enable
- reg_dst  out  2  write register: 0 = rt, 1 = rd, 2 = $31
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B input: 0 = B, 1 = 4, 2 = sign-extended imm, 3 = sign-extended imm<<2
- alu_op  out  3  ALU operation code
- pc_source  out  2  PC source: 0 = ALU, 1 = ALUOut, 2 = jump target, EXC_VEC_SEL = exception vector
- mem_to_reg  out  4  writeback source
- epc_write  out  1  EPC load
- halted  out  1  high in HALT

Behaviour:
- Outputs are a Moore decode of the state. Every output defaults to 0 in every state unless listed below.
- On reset, state goes to FETCH on the next edge and all outputs are 0 during the reset cycle. Reset mid-instruction aborts it with no further writes.
- FETCH:
  - i_or_d=0; load wait_cnt=MEM_WAIT.
  - If MEM_WAIT=0, go directly to FETCH_LD; otherwise go to FETCH_WAIT.
- FETCH_WAIT: decrement wait_cnt; at 1, go to FETCH_LD. The counter never wraps.
- FETCH_LD: ir_write=1, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0, pc_write=1. Next state is DECODE.
- DECODE: alu_src_b=3, alu_op=ADD (branch target into ALUOut). Dispatch on opcode:
  - 0x00, funct 0x20/0x22/0x24/0x25/0x2A -> EXEC_R
  - 0x00, funct 0x0D -> HALT
  - 0x08 -> EXEC_I
  - 0x23 / 0x2B -> MEM_ADDR
  - 0x04 / 0x05 -> BRANCH
  - 0x0F -> LUI_WB
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - anything else -> EXC
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op from funct. Next state is WB_R.
- WB_R: reg_write=1, reg_dst=1. mem_to_reg=0 (ALUOut), except slt uses mem_to_reg=1 (LT flag). Next state is FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=ADD. Next state is WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0. Next state is FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD. Next state is MEM_ACC.
- MEM_ACC: i_or_d=1; mem_write=1 for sw, held through the wait. Load wait_cnt and count as in fetch. Then go to WB_MEM for lw, FETCH for sw.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=3 (MDR). Next state is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_write_cond=1, pc_source=1; branch_ne=1 for opcode 0x05. Next state is FETCH.
- LUI_WB: reg_write=1, reg_dst=0, mem_to_reg=7 (imm<<16). Next state is FETCH.
- JUMP: pc_write=1, pc_source=2. Next state is FETCH.
- JAL: reg_write=1, reg_dst=2, mem_to_reg=4 (PC), pc_write=1, pc_source=2. Next state is FETCH.
- EXC: epc_write=1, pc_write=1, pc_source=EXC_VEC_SEL, reg_write=1, reg_dst=2, mem_to_reg=5 (constant 227). Next state is FETCH.
- HALT: halted=1. Absorbing; only reset leaves it.
- Opcode and funct are sampled only in DECODE and in states that read them. The IR is stable from FETCH_LD until the next FETCH_LD.

Optional Feature:
- Macro: CTRL_OVF_TRAP_EN.
- Defined:
  - Overflow=1 in EXEC_R (add/sub) or EXEC_I diverts the next state to EXC instead of WB_R/WB_I.
  - The destination register is not written.
- Undefined: overflow is ignored.

Decomposition:
- Package multicycle_pkg holds:
  - the state enum
  - opcode and funct localparams
  - alu_op codes: ADD=2, SUB=6, AND=0, OR=1, SLT=7
  - mem_to_reg codes: ALU=0, LT=1, MDR=3, PC=4, EXC_CONST=5, LUI=7
- One sub-module, mem_wait_counter: load/decrement counter with a done flag.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset; FETCH on the first cycle after release; ir_write pulses exactly MEM_WAIT+1 cycles later.
- add (opcode 0, funct 0x20) -> EXEC_R then WB_R with reg_write=1, reg_dst=1, mem_to_reg=0; total 5 cycles at MEM_WAIT=0.
- lw, then sw, at MEM_WAIT=2 ->
  - lw: i_or_d=1 for 3 cycles, then WB_MEM with mem_to_reg=3.
  - sw: mem_write=1 for 3 cycles, reg_write never asserted.
- bne with zero=1 and with zero=0 -> pc_write_cond=1, branch_ne=1, pc_source=1 in both cases.
- Opcode 0x3F -> EXC with epc_write=1, pc_source=3, mem_to_reg=5, reg_dst=2. Then funct 0x0D -> halted=1, held until reset.
- With CTRL_OVF_TRAP_EN, addi with overflow=1 -> EXC and no WB_I. Without the macro -> WB_I with reg_write=1.
